// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared types and widths for the SPI master scheduler
package spi_sched_pkg;

    localparam int SPI_CMD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-requester round-robin selector
module spi_rr_arb2
    import spi_sched_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t last_served,
    output logic     gnt_valid,
    output port_id_t gnt_id
);

    assign gnt_valid = req0 | req1;
    // On a tie the port that was not served last wins.
    assign gnt_id    = (req0 & req1) ? ~last_served : req1;

endmodule

// File: rtl/spi_sched.sv
// rtl/spi_sched.sv - shares one SPI master between two requesters; SPI_SCHED_TIMEOUT_EN adds a WAIT_DONE timeout
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [SPI_CMD_W-1:0] cmd0,
    input  logic                 req1,
    input  logic [SPI_CMD_W-1:0] cmd1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [SPI_CMD_W-1:0] rd_data,
    output logic                 err,
    output logic                 busy,
    output logic                 wrt,
    output logic [SPI_CMD_W-1:0] spi_cmd,
    input  logic                 spi_done,
    input  logic [SPI_CMD_W-1:0] spi_rd_data
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("spi_sched: parameter out of range");
    end

    state_t                 state_q, state_d;
    port_id_t               owner_q, owner_d;
    port_id_t               last_q, last_d;
    logic [SPI_CMD_W-1:0]   cmd_q, cmd_d;
    logic [SPI_CMD_W-1:0]   rd_q, rd_d;
    logic [7:0]             gap_q, gap_d;
    logic                   done_q;
    logic                   done_rise;
    logic                   cpl;
    logic                   tmo;
    logic                   finish;
    logic                   gnt_valid;
    port_id_t               gnt_id;

    spi_rr_arb2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_q),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id)
    );

    // A done level left over from the previous transaction never shows a rise.
    assign done_rise = spi_done & ~done_q;
    assign cpl       = (state_q == WAIT_DONE) & done_rise;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q, to_d;

    assign tmo  = (state_q == WAIT_DONE) & ~done_rise & (to_q == TO_W'(TIMEOUT_CYCLES));
    assign to_d = (state_q == WAIT_DONE) ? to_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) to_q <= '0;
        else     to_q <= to_d;
    end
`else
    assign tmo = 1'b0;
`endif

    assign finish = cpl | tmo;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        rd_d    = rd_q;
        gap_d   = gap_q;
        wrt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_id;
                    cmd_d   = gnt_id ? cmd1 : cmd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wrt     = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (finish) begin
                    rd_d    = cpl ? spi_rd_data : '0;
                    last_d  = owner_q;
                    gap_d   = 8'(GAP_CYCLES);
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            rd_q    <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            rd_q    <= rd_d;
            gap_q   <= gap_d;
            done_q  <= spi_done;
        end
    end

    // rd_d carries the response in the ack cycle so the word is visible alongside ack.
    assign rd_data = rd_d;
    assign ack0    = finish & (owner_q == 1'b0);
    assign ack1    = finish & (owner_q == 1'b1);
    assign err     = tmo;
    assign busy    = (state_q != IDLE);
    assign spi_cmd = cmd_q;

endmodule

// File: tb/tb_spi_sched.sv
// tb/tb_spi_sched.sv - directed self-checking bench for spi_sched
module tb_spi_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] cmd0, cmd1;
    logic        ack0, ack1, err, busy, wrt;
    logic [15:0] rd_data, spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ack_cyc;
    int wrt_cyc;

    spi_sched #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .cmd0        (cmd0),
        .req1        (req1),
        .cmd1        (cmd1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rd_data     (rd_data),
        .err         (err),
        .busy        (busy),
        .wrt         (wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        spi_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_wrt(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (wrt) begin
                wrt_cyc = cyc;
                return;
            end
            tick();
        end
        chk({tag, "_wrt_tmo"}, 32'd0, 32'd1);
    endtask

    // Raise done with data, expect the ack of port in the same cycle, then drop req and done.
    task automatic complete(input string tag, input int port, input logic [15:0] data);
        spi_rd_data = data;
        spi_done    = 1'b1;
        #1;
        ack_cyc = cyc;
        chk({tag, "_ack0"}, 32'(ack0), 32'(port == 0));
        chk({tag, "_ack1"}, 32'(ack1), 32'(port == 1));
        chk({tag, "_rd"},   32'(rd_data), 32'(data));
        chk({tag, "_err"},  32'(err), 32'd0);
        tick();
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        spi_done    = 1'b0;
        spi_rd_data = 16'hDEAD;
        #1;
        chk({tag, "_ack_pulse"}, 32'(ack0 | ack1), 32'd0);
        chk({tag, "_rd_hold"},   32'(rd_data), 32'(data));
    endtask

    initial begin
        int exp_id [4] = '{0, 1, 0, 1};
        cmd0 = 16'h0; cmd1 = 16'h0; spi_rd_data = 16'h0;
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrt",  32'(wrt), 32'd0);
        chk("rst_ack",  32'({ack0, ack1}), 32'd0);
        chk("rst_err",  32'(err), 32'd0);
        chk("rst_rd",   32'(rd_data), 32'h0);
        chk("rst_cmd",  32'(spi_cmd), 32'h0);

        // single request
        req0 = 1'b1; cmd0 = 16'hA5A5;
        wait_wrt("s1");
        chk("s1_cmd", 32'(spi_cmd), 32'hA5A5);
        cmd0 = 16'hFFFF;
        tick();
        chk("s1_one_wrt", 32'(wrt), 32'd0);
        chk("s1_cmd_held", 32'(spi_cmd), 32'hA5A5);
        chk("s1_busy", 32'(busy), 32'd1);
        tick(); tick();
        complete("s1", 0, 16'h1234);

        // simultaneous requests: 0,1,0,1 with exact gap
        do_reset();
        req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h1111; cmd1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            wait_wrt("s2");
            if (k > 0) chk("s2_gap", 32'(wrt_cyc - ack_cyc), 32'd6);
            chk("s2_cmd", 32'(spi_cmd), exp_id[k] ? 32'h2222 : 32'h1111);
            tick(); tick();
            complete("s2", exp_id[k], 16'(16'h0100 + k));
            tick();
            if (exp_id[k] == 0) req0 = 1'b1; else req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("s2_idle", 32'(busy), 32'd0);

        // stale done level
        spi_done = 1'b1;
        req0 = 1'b1; cmd0 = 16'h0F0F;
        wait_wrt("s3");
        tick();
        chk("s3_stale_hi", 32'(ack0 | ack1), 32'd0);
        spi_done = 1'b0;
        tick();
        chk("s3_stale_lo", 32'(ack0 | ack1), 32'd0);
        tick();
        complete("s3", 0, 16'hBEEF);
        for (int i = 0; i < 8; i++) tick();

        // reset in WAIT_DONE
        req0 = 1'b1; cmd0 = 16'h3333;
        wait_wrt("s5");
        for (int i = 0; i < 10; i++) tick();
        chk("s5_waiting", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_noack", 32'(ack0 | ack1), 32'd0);
        chk("s5_cmd", 32'(spi_cmd), 32'h0);
        wait_wrt("s5b");
        chk("s5b_cmd", 32'(spi_cmd), 32'h3333);
        tick();
        complete("s5b", 0, 16'h5A5A);
        for (int i = 0; i < 8; i++) tick();

`ifdef SPI_SCHED_TIMEOUT_EN
        req1 = 1'b1; cmd1 = 16'h7777;
        wait_wrt("s6");
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (ack0 | ack1) begin
                    seen = 1'b1;
                    chk("s6_lat", 32'(cyc - wrt_cyc), 32'd17);
                    chk("s6_ack1", 32'(ack1), 32'd1);
                    chk("s6_err", 32'(err), 32'd1);
                    chk("s6_rd", 32'(rd_data), 32'h0);
                end
            end
            if (!seen) chk("s6_no_ack", 32'd0, 32'd1);
        end
        tick();
        req1 = 1'b0;
        chk("s6_err_pulse", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
